// File: rtl/link_frame_gen.sv
// link_frame_gen
// Transmit-side framer feeding the 5-word-to-2-lane DDR output interface.
// Every clock it produces one 5 x 14-bit frame. After reset or a training
// request it sends TRAIN_FRAMES training frames. It then repeats a cycle of
// one sync frame followed by (SYNC_PERIOD-1) data frames. A data frame carries
// user payload, a ramp test pattern or a constant pattern, depending on the
// mode latched during the preceding sync frame.
//
// Ports:
//   clk           single clock, also the word clock of the DDR interface
//   reset         synchronous, active-high
//   train_req     single-cycle request to restart training
//   mode          0=payload, 1=ramp, 2=constant TRAIN_WORD, 3=payload
//   s_data        payload frame, slot 0 transmitted first
//   s_valid       payload frame valid
//   s_ready       payload is accepted this cycle (s_valid && s_ready)
//   data_out      registered frame to the DDR interface
//   frame_marker  data_out carries a sync frame
//   training      data_out carries a training frame
//   underflow_cnt saturating count of idle-filled payload frames
//   seq_num       sequence number carried by the last sync frame sent
module link_frame_gen #(
  parameter int          TRAIN_FRAMES = 64,
  parameter int          SYNC_PERIOD  = 1024,
  parameter logic [13:0] TRAIN_WORD   = 14'h15AA,
  parameter logic [13:0] SYNC_WORD    = 14'h3E0C,
  parameter logic [13:0] IDLE_WORD    = 14'h0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             train_req,
  input  logic [1:0]       mode,
  input  logic [4:0][13:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [4:0][13:0] data_out,
  output logic             frame_marker,
  output logic             training,
  output logic [15:0]      underflow_cnt,
  output logic [13:0]      seq_num
);

  localparam int FC_MAX = (TRAIN_FRAMES > SYNC_PERIOD) ? TRAIN_FRAMES : SYNC_PERIOD;
  localparam int FC_W   = (FC_MAX > 1) ? $clog2(FC_MAX) : 1;

  // Last frame index of each counted state. DATA lasts SYNC_PERIOD-1 frames.
  localparam logic [FC_W-1:0] TRAIN_LAST = FC_W'(TRAIN_FRAMES - 1);
  localparam logic [FC_W-1:0] DATA_LAST  = FC_W'(SYNC_PERIOD - 2);

  typedef enum logic [1:0] {
    ST_TRAIN = 2'd0,
    ST_SYNC  = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic [13:0]     seq_q, seq_d;
  logic [13:0]     ramp_q, ramp_d;
  logic [1:0]      mode_q, mode_d;

  logic [4:0][13:0] frame_d;
  logic             marker_d;
  logic             training_d;
  logic             ready_d;
  logic [15:0]      underflow_d;
  logic [13:0]      seq_num_d;

  // State register and output registers. The frame chosen in this cycle
  // becomes visible on data_out in the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_TRAIN;
      fc_q          <= '0;
      seq_q         <= '0;
      ramp_q        <= '0;
      mode_q        <= 2'd0;
      data_out      <= {5{IDLE_WORD}};
      frame_marker  <= 1'b0;
      training      <= 1'b0;
      s_ready       <= 1'b0;
      underflow_cnt <= '0;
      seq_num       <= '0;
    end else begin
      state_q       <= state_d;
      fc_q          <= fc_d;
      seq_q         <= seq_d;
      ramp_q        <= ramp_d;
      mode_q        <= mode_d;
      data_out      <= frame_d;
      frame_marker  <= marker_d;
      training      <= training_d;
      s_ready       <= ready_d;
      underflow_cnt <= underflow_d;
      seq_num       <= seq_num_d;
    end
  end

  // Next-state and frame selection.
  always_comb begin
    state_d     = state_q;
    fc_d        = fc_q;
    seq_d       = seq_q;
    ramp_d      = ramp_q;
    mode_d      = mode_q;
    frame_d     = {5{IDLE_WORD}};
    marker_d    = 1'b0;
    training_d  = 1'b0;
    underflow_d = underflow_cnt;
    seq_num_d   = seq_num;

    case (state_q)
      ST_TRAIN: begin
        frame_d    = {5{TRAIN_WORD}};
        training_d = 1'b1;
        if (fc_q == TRAIN_LAST) begin
          state_d = ST_SYNC;
          fc_d    = '0;
        end else begin
          fc_d = fc_q + 1'b1;
        end
      end

      ST_SYNC: begin
        // Slot 3 reports the mode sampled now. That mode governs the
        // data period that follows this sync frame.
        frame_d[0] = SYNC_WORD;
        frame_d[1] = ~SYNC_WORD;
        frame_d[2] = seq_q;
        frame_d[3] = {12'b0, mode};
        frame_d[4] = SYNC_WORD;
        marker_d   = 1'b1;
        seq_d      = seq_q + 14'd1;
        seq_num_d  = seq_q;
        mode_d     = mode;
        state_d    = ST_DATA;
        fc_d       = '0;
      end

      ST_DATA: begin
        case (mode_q)
          2'd1: begin
            // The ramp continues across sync frames and wraps at 2^14.
            for (int k = 0; k < 5; k++) begin
              frame_d[k] = ramp_q + 14'(k);
            end
            ramp_d = ramp_q + 14'd5;
          end
          2'd2: begin
            frame_d = {5{TRAIN_WORD}};
          end
          default: begin
            if (s_valid) begin
              frame_d = s_data;
            end else if (underflow_cnt != 16'hFFFF) begin
              underflow_d = underflow_cnt + 16'd1;
            end
          end
        endcase
        if (fc_q == DATA_LAST) begin
          state_d = ST_SYNC;
          fc_d    = '0;
        end else begin
          fc_d = fc_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_TRAIN;
        fc_d    = '0;
      end
    endcase

    // A training request overrides whatever follows the current frame.
    // The current frame still completes, so an accepted payload is not lost.
    if (train_req) begin
      state_d = ST_TRAIN;
      fc_d    = '0;
    end

    // s_ready is high exactly in the cycles that choose a payload-mode data frame.
    ready_d = (state_d == ST_DATA) && ((mode_d == 2'd0) || (mode_d == 2'd3));
  end

endmodule
